zsample_fetch: RTL and testbench
================================

// Module: zsample_fetch
// PURPOSE
//  Consumer end of the whitening-block sample interface. Starts the whitening block and
//  steps it one sample at a time with New_one. Captures each whitened vector Z1..Z4 into
//  an internal buffer of N_SAMPLES entries. Serves the buffer to the FastICA iteration
//  core through a registered read port.
// PARAMETERS
//  N_SAMPLES    256  whitened vectors captured per run (>=2)
//  ADDR_W       8    buffer address width, 2**ADDR_W >= N_SAMPLES
//  BUSY_TIMEOUT 15   max cycles waiting for Whitening_busy to rise before error (<=255)
// PORTS
//  CLK_zfetch      in   1        clock, all logic on rising edge
//  RSTn_zfetch     in   1        asynchronous active-low reset
//  GO_zfetch       in   1        1-cycle start pulse; ignored while Zfetch_busy=1
//  Whitening_busy  in   1        whitening block computing; Z1..Z4 valid when 0
//  Z1..Z4          in   26 each  signed whitened sample components
//  GO_whitening    out  1        enable to whitening block, high from start to run end
//  New_one         out  1        1-cycle request for next whitened sample
//  Zfetch_busy     out  1        run in progress
//  Zfetch_done     out  1        1-cycle pulse, N_SAMPLES captured
//  Zfetch_err      out  1        sticky timeout flag, cleared by next accepted GO_zfetch
//  Sample_count    out  ADDR_W+1 vectors captured this run
//  Rd_en           in   1        read request
//  Rd_addr         in   ADDR_W   read index
//  Rd_valid        out  1        read data valid, 1 cycle after Rd_en
//  Rd_Z1..Rd_Z4    out  26 each  signed read data
// BEHAVIOUR
//  Reset: all outputs 0, including Rd_Z*. FSM goes to IDLE, Sample_count=0, timeout
//   counter=0. Buffer contents are not cleared.
//  FSM states: IDLE, START, WAIT_HI, WAIT_LO, CAPTURE, REQ, DONE.
//   IDLE    : on GO_zfetch, clear Sample_count and Zfetch_err, set GO_whitening=1 -> START.
//   START   : 1 cycle -> WAIT_HI. This lets the whitening block see GO.
//   WAIT_HI : wait for Whitening_busy=1 -> WAIT_LO. Timeout counter increments each cycle
//             here. If the counter reaches BUSY_TIMEOUT: Zfetch_err=1, GO_whitening=0 -> IDLE.
//   WAIT_LO : wait for Whitening_busy=0 -> CAPTURE. No timeout in this state.
//   CAPTURE : buf[Sample_count]={Z1,Z2,Z3,Z4} sampled this cycle; Sample_count+1. If the new
//             count == N_SAMPLES -> DONE, else -> REQ.
//   REQ     : New_one=1 for exactly this cycle; reset timeout counter -> WAIT_HI.
//   DONE    : Zfetch_done=1 for 1 cycle, GO_whitening=0 -> IDLE.
//  Zfetch_busy=1 in every state except IDLE. New_one is never asserted for the last sample.
//  Read port: on Rd_en, the next cycle gives Rd_valid=1 and Rd_Z*=buf[Rd_addr].
//   Reads are permitted in any state.
//   If Rd_addr == the CAPTURE write address in the same cycle, the read returns the old data.
//   If Rd_addr >= Sample_count, the read returns Rd_Z*=0 with Rd_valid=1.
//   Rd_Z* holds its value when Rd_en=0. Rd_valid is a 1-cycle pulse.
//  Data width: components are stored and returned unmodified. Signed 26-bit, no rounding.
//  GO_zfetch during a run is ignored, with no effect on count or flags.
//  Reset mid-run: immediate return to IDLE. GO_whitening and New_one deassert asynchronously.
//   The next run overwrites the buffer starting at index 0.
// TESTING
//  1 Reset, then GO_zfetch. The whitening model raises busy 1 cycle after GO/New_one, holds it
//    3 cycles, and presents Z1..Z4=k,-k,2k,-2k for sample k. Required: N_SAMPLES New_one
//    pulses minus 1, one Zfetch_done pulse, Sample_count=N_SAMPLES.
//  2 After test 1, read addresses 0, 5 and N_SAMPLES-1. Required: Rd_valid 1 cycle later, and
//    Rd_Z1..Rd_Z4 = (k,-k,2k,-2k) for each address k. Use Z=-2**25 and 2**25-1 extremes on
//    sample 5 to check sign and width.
//  3 Whitening model never raises busy after the first New_one. Required: Zfetch_err=1
//    exactly BUSY_TIMEOUT cycles after entering WAIT_HI, GO_whitening=0, Sample_count=1.
//    A following GO_zfetch clears Zfetch_err.
//  4 Pulse GO_zfetch again at sample 10 of a run. Required: no restart, and the count
//    continues 11, 12, ...
//  5 Assert RSTn_zfetch=0 at sample 20, then release and start again. Required: all outputs
//    0 during reset, and the new run captures from index 0.
//  6 Rd_en with Rd_addr=7 in the same cycle CAPTURE writes index 7. Required: old data
//    returned; a repeat read returns the new vector. Reading Rd_addr>=Sample_count returns 0.

Source files
------------

// File: rtl/zsample_fetch_if.sv
// Sample and read-port signals between the whitening block, zsample_fetch and the FastICA core.
// slave is the zsample_fetch side; master is the side that drives the whitening/read inputs.
interface zsample_fetch_if #(
  parameter int ADDR_W = 8
);
  logic                     GO_zfetch;
  logic                     Whitening_busy;
  logic signed [25:0]       Z1;
  logic signed [25:0]       Z2;
  logic signed [25:0]       Z3;
  logic signed [25:0]       Z4;
  logic                     GO_whitening;
  logic                     New_one;
  logic                     Zfetch_busy;
  logic                     Zfetch_done;
  logic                     Zfetch_err;
  logic [ADDR_W:0]          Sample_count;
  logic                     Rd_en;
  logic [ADDR_W-1:0]        Rd_addr;
  logic                     Rd_valid;
  logic signed [25:0]       Rd_Z1;
  logic signed [25:0]       Rd_Z2;
  logic signed [25:0]       Rd_Z3;
  logic signed [25:0]       Rd_Z4;

  modport slave (
    input  GO_zfetch, Whitening_busy, Z1, Z2, Z3, Z4, Rd_en, Rd_addr,
    output GO_whitening, New_one, Zfetch_busy, Zfetch_done, Zfetch_err, Sample_count,
           Rd_valid, Rd_Z1, Rd_Z2, Rd_Z3, Rd_Z4
  );

  modport master (
    output GO_zfetch, Whitening_busy, Z1, Z2, Z3, Z4, Rd_en, Rd_addr,
    input  GO_whitening, New_one, Zfetch_busy, Zfetch_done, Zfetch_err, Sample_count,
           Rd_valid, Rd_Z1, Rd_Z2, Rd_Z3, Rd_Z4
  );
endinterface

// File: rtl/zsample_fetch.sv
// Steps the whitening block one sample at a time, captures N_SAMPLES Z vectors into block RAM
// and serves them to the FastICA core through a registered read port.
module zsample_fetch #(
  parameter int N_SAMPLES    = 256,
  parameter int ADDR_W       = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic          CLK_zfetch,
  input  logic          RSTn_zfetch,
  zsample_fetch_if.slave zif
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] N_LAST   = CW'(N_SAMPLES);
  localparam logic [7:0]    TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_CAPTURE, S_REQ, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [7:0]      tmo_reg, tmo_next;
  logic            err_reg, err_next;
  logic            gow_reg, gow_next;
  logic            rd_valid_reg;
  logic            rd_inrange_reg;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [25:0] z_in [4];
  logic [3:0][25:0]  rd_z;

  always_ff @(posedge CLK_zfetch or negedge RSTn_zfetch) begin
    if (!RSTn_zfetch) begin
      state_reg      <= S_IDLE;
      count_reg      <= '0;
      tmo_reg        <= '0;
      err_reg        <= 1'b0;
      gow_reg        <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_inrange_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      tmo_reg      <= tmo_next;
      err_reg      <= err_next;
      gow_reg      <= gow_next;
      rd_valid_reg <= zif.Rd_en;
      // Range is judged against the post-edge count so the index being written this
      // cycle is readable (returning its pre-write contents).
      if (zif.Rd_en) begin
        rd_inrange_reg <= ({1'b0, zif.Rd_addr} < count_next);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;
    gow_next   = gow_reg;
    case (state_reg)
      S_IDLE: begin
        if (zif.GO_zfetch) begin
          count_next = '0;
          tmo_next   = '0;
          err_next   = 1'b0;
          gow_next   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (zif.Whitening_busy) begin
          state_next = S_WAIT_LO;
        end else if (tmo_reg == TMO_LAST) begin
          err_next   = 1'b1;
          gow_next   = 1'b0;
          state_next = S_IDLE;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      S_WAIT_LO: begin
        if (!zif.Whitening_busy) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        count_next = count_reg + 1'b1;
        state_next = ((count_reg + 1'b1) == N_LAST) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        tmo_next   = '0;
        state_next = S_WAIT_HI;
      end
      S_DONE: begin
        gow_next   = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_en   = (state_reg == S_CAPTURE);
  assign wr_addr = count_reg[ADDR_W-1:0];
  assign z_in[0] = zif.Z1;
  assign z_in[1] = zif.Z2;
  assign z_in[2] = zif.Z3;
  assign z_in[3] = zif.Z4;

  // One RAM lane per component; the raw read register is not reset, the range flag masks it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [25:0] mem [N_SAMPLES];
      logic [25:0] q_reg;

      always_ff @(posedge CLK_zfetch) begin
        if (wr_en) begin
          mem[wr_addr] <= z_in[gi];
        end
        if (zif.Rd_en) begin
          q_reg <= mem[zif.Rd_addr];
        end
      end

      assign rd_z[gi] = rd_inrange_reg ? q_reg : 26'd0;
    end
  endgenerate

  assign zif.GO_whitening = gow_reg;
  assign zif.New_one      = (state_reg == S_REQ);
  assign zif.Zfetch_busy  = (state_reg != S_IDLE);
  assign zif.Zfetch_done  = (state_reg == S_DONE);
  assign zif.Zfetch_err   = err_reg;
  assign zif.Sample_count = count_reg;
  assign zif.Rd_valid     = rd_valid_reg;
  assign zif.Rd_Z1        = rd_z[0];
  assign zif.Rd_Z2        = rd_z[1];
  assign zif.Rd_Z3        = rd_z[2];
  assign zif.Rd_Z4        = rd_z[3];
endmodule

// File: tb/tb_zsample_fetch.sv
// Directed bench for zsample_fetch: whitening-block model, capture runs, timeout,
// ignored restart, mid-run reset and read-port corner cases.
module tb_zsample_fetch;
  localparam int N   = 256;
  localparam int AW  = 8;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zsample_fetch_if #(.ADDR_W(AW)) zif();

  zsample_fetch #(.N_SAMPLES(N), .ADDR_W(AW), .BUSY_TIMEOUT(TMO)) dut (
    .CLK_zfetch (clk),
    .RSTn_zfetch(rst_n),
    .zif        (zif.slave)
  );

  int vecs = 0;
  int misses = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whitening model: busy rises on the edge that sees GO rise or New_one, stays 3 cycles,
  // then drops with sample mk presented on Z1..Z4.
  logic model_mute = 1'b0;
  int   z_base = 0;
  int   mk;
  int   bcnt;
  logic go_prev;

  function automatic logic signed [25:0] zval(input int k, input int c);
    int v;
    v = k + z_base;
    if (k == 5) return (c % 2 == 0) ? 26'sh2000000 : 26'sh1FFFFFF;
    case (c)
      0:       return 26'(v);
      1:       return 26'(-v);
      2:       return 26'(2 * v);
      default: return 26'(-2 * v);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zif.Whitening_busy <= 1'b0;
      zif.Z1 <= '0; zif.Z2 <= '0; zif.Z3 <= '0; zif.Z4 <= '0;
      bcnt <= 0; mk <= 0; go_prev <= 1'b0;
    end else begin
      go_prev <= zif.GO_whitening;
      if (zif.GO_whitening && !go_prev) begin
        mk <= 0;
        zif.Whitening_busy <= 1'b1;
        bcnt <= 3;
      end else if (zif.New_one) begin
        mk <= mk + 1;
        if (!model_mute) begin
          zif.Whitening_busy <= 1'b1;
          bcnt <= 3;
        end
      end else if (zif.Whitening_busy) begin
        if (bcnt == 1) begin
          zif.Whitening_busy <= 1'b0;
          zif.Z1 <= zval(mk, 0); zif.Z2 <= zval(mk, 1);
          zif.Z3 <= zval(mk, 2); zif.Z4 <= zval(mk, 3);
        end else begin
          bcnt <= bcnt - 1;
        end
      end
    end
  end

  int n_new = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (zif.New_one) n_new++;
    if (zif.Zfetch_done) n_done++;
  end

  typedef struct {
    int addr;
    int z1, z2, z3, z4;
  } rd_vec_t;

  task automatic pulse_go();
    zif.GO_zfetch = 1'b1;
    tick();
    zif.GO_zfetch = 1'b0;
  endtask

  task automatic wait_count(input int v);
    for (int i = 0; i < 3000 && int'(zif.Sample_count) != v; i++) tick();
    chk($sformatf("count reaches %0d", v), int'(zif.Sample_count), v);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && !zif.Zfetch_done; i++) tick();
    chk("done pulse seen", int'(zif.Zfetch_done), 1);
  endtask

  task automatic read_check(input rd_vec_t v);
    zif.Rd_en = 1'b1;
    zif.Rd_addr = AW'(v.addr);
    tick();
    zif.Rd_en = 1'b0;
    chk($sformatf("rd[%0d].valid", v.addr), int'(zif.Rd_valid), 1);
    chk($sformatf("rd[%0d].z1", v.addr), int'(zif.Rd_Z1), v.z1);
    chk($sformatf("rd[%0d].z2", v.addr), int'(zif.Rd_Z2), v.z2);
    chk($sformatf("rd[%0d].z3", v.addr), int'(zif.Rd_Z3), v.z3);
    chk($sformatf("rd[%0d].z4", v.addr), int'(zif.Rd_Z4), v.z4);
    tick();
    chk($sformatf("rd[%0d].valid_pulse", v.addr), int'(zif.Rd_valid), 0);
    chk($sformatf("rd[%0d].z1_hold", v.addr), int'(zif.Rd_Z1), v.z1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".go_whitening"}, int'(zif.GO_whitening), 0);
    chk({tag, ".new_one"}, int'(zif.New_one), 0);
    chk({tag, ".busy"}, int'(zif.Zfetch_busy), 0);
    chk({tag, ".done"}, int'(zif.Zfetch_done), 0);
    chk({tag, ".err"}, int'(zif.Zfetch_err), 0);
    chk({tag, ".count"}, int'(zif.Sample_count), 0);
    chk({tag, ".rd_valid"}, int'(zif.Rd_valid), 0);
    chk({tag, ".rd_z1"}, int'(zif.Rd_Z1), 0);
    chk({tag, ".rd_z4"}, int'(zif.Rd_Z4), 0);
  endtask

  rd_vec_t rv [6];
  rd_vec_t r0_new;
  rd_vec_t r7_old, r7_new, r8_oor;

  initial begin
    rv[0] = '{0,   0,         0,        0,         0};
    rv[1] = '{1,   1,         -1,       2,         -2};
    rv[2] = '{5,   -33554432, 33554431, -33554432, 33554431};
    rv[3] = '{128, 128,       -128,     256,       -256};
    rv[4] = '{254, 254,       -254,     508,       -508};
    rv[5] = '{255, 255,       -255,     510,       -510};
    r0_new = '{0, 1000, -1000, 2000, -2000};
    r7_old = '{7, 7, -7, 14, -14};
    r7_new = '{7, 1007, -1007, 2014, -2014};
    r8_oor = '{8, 0, 0, 0, 0};

    zif.GO_zfetch = 1'b0;
    zif.Rd_en = 1'b0;
    zif.Rd_addr = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full capture run
    n_new = 0;
    n_done = 0;
    pulse_go();
    chk("run1.busy", int'(zif.Zfetch_busy), 1);
    chk("run1.go_whitening", int'(zif.GO_whitening), 1);
    wait_done();
    chk("run1.count_at_done", int'(zif.Sample_count), N);
    tick();
    chk("run1.new_one_pulses", n_new, N - 1);
    chk("run1.done_pulses", n_done, 1);
    chk("run1.busy_after", int'(zif.Zfetch_busy), 0);
    chk("run1.go_whitening_after", int'(zif.GO_whitening), 0);

    // Buffer readback including sign/width extremes at index 5
    for (int i = 0; i < 6; i++) read_check(rv[i]);

    // Timeout: busy never rises after the first New_one
    model_mute = 1'b1;
    pulse_go();
    for (int i = 0; i < 100 && !zif.New_one; i++) tick();
    chk("tmo.new_one_seen", int'(zif.New_one), 1);
    tick();
    repeat (TMO - 1) tick();
    chk("tmo.err_before", int'(zif.Zfetch_err), 0);
    chk("tmo.go_before", int'(zif.GO_whitening), 1);
    tick();
    chk("tmo.err", int'(zif.Zfetch_err), 1);
    chk("tmo.go_whitening", int'(zif.GO_whitening), 0);
    chk("tmo.count", int'(zif.Sample_count), 1);
    chk("tmo.busy", int'(zif.Zfetch_busy), 0);
    model_mute = 1'b0;
    pulse_go();
    chk("tmo.err_cleared", int'(zif.Zfetch_err), 0);
    chk("tmo.restart_busy", int'(zif.Zfetch_busy), 1);

    // GO during a run is ignored
    wait_count(10);
    pulse_go();
    chk("rego.busy", int'(zif.Zfetch_busy), 1);
    chk("rego.count_kept", int'(zif.Sample_count), 10);
    wait_count(11);
    wait_count(12);
    wait_done();
    chk("rego.count_at_done", int'(zif.Sample_count), N);
    tick();

    // Reset in the middle of a run
    pulse_go();
    wait_count(20);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // New run overwrites from index 0; read/write collision on index 7
    z_base = 1000;
    pulse_go();
    wait_count(1);
    read_check(r0_new);
    for (int i = 0; i < 200 && !(zif.New_one && int'(zif.Sample_count) == 7); i++) tick();
    chk("coll.req7_seen", int'(zif.Sample_count), 7);
    for (int i = 0; i < 20 && !zif.Whitening_busy; i++) tick();
    for (int i = 0; i < 20 && zif.Whitening_busy; i++) tick();
    tick();
    zif.Rd_en = 1'b1;
    zif.Rd_addr = 8'd7;
    tick();
    chk("coll.count_after_write", int'(zif.Sample_count), 8);
    chk("coll.valid", int'(zif.Rd_valid), 1);
    chk("coll.old_z1", int'(zif.Rd_Z1), r7_old.z1);
    chk("coll.old_z2", int'(zif.Rd_Z2), r7_old.z2);
    chk("coll.old_z3", int'(zif.Rd_Z3), r7_old.z3);
    chk("coll.old_z4", int'(zif.Rd_Z4), r7_old.z4);
    zif.Rd_en = 1'b0;
    read_check(r7_new);
    read_check(r8_oor);
    wait_done();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end
endmodule
